// File: rtl/uart_pwm_cmd_ctrl.sv
// uart_pwm_cmd_ctrl
// Parses 4-byte command frames (HDR, CH, DUTY, CSUM) from the UART receiver,
// stages duty values in per-channel shadow registers and commits them to the
// PWM-facing active registers only at a PWM period boundary.

module uart_pwm_cmd_ctrl #(
   parameter int          NUM_CH       = 4,
   parameter int          TIMEOUT_CLKS = 8680,
   parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_Period_Start,
   output logic [NUM_CH*8-1:0]   o_Duty,
   output logic                  o_Cmd_Ack,
   output logic                  o_Cmd_Err,
   output logic [7:0]            o_Err_Count,
   output logic                  o_Busy
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GET_CH   = 2'd1;
   localparam logic [1:0] ST_GET_DUTY = 2'd2;
   localparam logic [1:0] ST_GET_CSUM = 2'd3;

   localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [8:0] NUM_CH_W  = 9'(NUM_CH);

   logic [1:0]        state;
   logic [7:0]        ch_byte;
   logic [7:0]        duty_byte;
   logic [TW-1:0]     tcount;
   logic [7:0]        shadow [NUM_CH];
   logic [NUM_CH-1:0] pending;

   logic frame_done;
   logic frame_ok;
   logic timeout_hit;
   logic err_event;
   logic write_en;

   // Frame completion, validity and timeout decisions for the current cycle
   always_comb begin
      frame_done  = i_RX_DV && (state == ST_GET_CSUM);
      frame_ok    = (i_RX_Byte == (HDR_BYTE ^ ch_byte ^ duty_byte)) &&
                    ({1'b0, ch_byte} < NUM_CH_W);
      timeout_hit = !i_RX_DV && (state != ST_IDLE) &&
                    (tcount == TW'(TIMEOUT_CLKS - 1));
      err_event   = (frame_done && !frame_ok) || timeout_hit;
      write_en    = frame_done && frame_ok;
   end

   // Parser FSM, inter-byte timeout, ack/err pulses and saturating error count
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= ST_IDLE;
         ch_byte     <= 8'h00;
         duty_byte   <= 8'h00;
         tcount      <= '0;
         o_Cmd_Ack   <= 1'b0;
         o_Cmd_Err   <= 1'b0;
         o_Err_Count <= 8'h00;
      end else begin
         o_Cmd_Ack <= write_en;
         o_Cmd_Err <= err_event;
         if (err_event && (o_Err_Count != 8'hFF)) begin
            o_Err_Count <= o_Err_Count + 8'd1;
         end
         if (i_RX_DV) begin
            tcount <= '0;
            case (state)
               ST_IDLE: begin
                  if (i_RX_Byte == HDR_BYTE) begin
                     state <= ST_GET_CH;
                  end
               end
               ST_GET_CH: begin
                  ch_byte <= i_RX_Byte;
                  state   <= ST_GET_DUTY;
               end
               ST_GET_DUTY: begin
                  duty_byte <= i_RX_Byte;
                  state     <= ST_GET_CSUM;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end else if (timeout_hit) begin
            state  <= ST_IDLE;
            tcount <= '0;
         end else if (state != ST_IDLE) begin
            tcount <= tcount + 1'b1;
         end
      end
   end

   // Shadow writes and period-boundary commits; a write landing on the same
   // cycle as a commit keeps its channel pending so it goes out next period
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         o_Duty  <= '0;
         pending <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            shadow[n] <= 8'h00;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (i_Period_Start && pending[n]) begin
               o_Duty[8*n +: 8] <= shadow[n];
               pending[n]       <= 1'b0;
            end
            if (write_en && (ch_byte == 8'(n))) begin
               shadow[n]  <= duty_byte;
               pending[n] <= 1'b1;
            end
         end
      end
   end

   assign o_Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// Testbench for uart_pwm_cmd_ctrl: directed frames checked every cycle
// against a behavioural model, plus hand-computed literal expectations.

module tb_uart_pwm_cmd_ctrl;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 8680;

   logic                clk;
   logic                rst;
   logic                dv;
   logic [7:0]          rxb;
   logic                ps;
   logic [NUM_CH*8-1:0] duty;
   logic                ack;
   logic                err;
   logic [7:0]          err_count;
   logic                busy;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   // Behavioural model state: bytes collected so far, silent clocks, channel data
   int m_count;
   int m_sil;
   int m_frame [4];
   int m_shadow [NUM_CH];
   int m_pend [NUM_CH];
   int m_duty [NUM_CH];
   int m_ack;
   int m_err;
   int m_cnt;

   uart_pwm_cmd_ctrl #(
      .NUM_CH(NUM_CH),
      .TIMEOUT_CLKS(TIMEOUT),
      .HDR_BYTE(8'hA5)
   ) dut (
      .i_Clock(clk),
      .i_Reset(rst),
      .i_RX_DV(dv),
      .i_RX_Byte(rxb),
      .i_Period_Start(ps),
      .o_Duty(duty),
      .o_Cmd_Ack(ack),
      .o_Cmd_Err(err),
      .o_Err_Count(err_count),
      .o_Busy(busy)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Records one comparison and reports it when it disagrees
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives the inputs for exactly one clock cycle, starting at a falling edge
   task automatic applyStimulus(input logic v, input logic [7:0] b, input logic p);
      @(negedge clk);
      dv  = v;
      rxb = b;
      ps  = p;
   endtask

   // Four consecutive data-valid bytes; optional period pulse on the final one
   task automatic sendFrame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] s, input logic last_ps);
      applyStimulus(1'b1, h, 1'b0);
      applyStimulus(1'b1, c, 1'b0);
      applyStimulus(1'b1, d, 1'b0);
      applyStimulus(1'b1, s, last_ps);
   endtask

   // One-cycle synchronous reset; returns at the falling edge after it took effect
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      dv  = 1'b0;
      ps  = 1'b0;
      rxb = 8'h00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Model update on every rising edge, written from the frame rules directly
   always @(posedge clk) begin
      if (rst) begin
         m_count = 0;
         m_sil   = 0;
         m_ack   = 0;
         m_err   = 0;
         m_cnt   = 0;
         for (int n = 0; n < NUM_CH; n++) begin
            m_shadow[n] = 0;
            m_pend[n]   = 0;
            m_duty[n]   = 0;
         end
      end else begin
         m_ack = 0;
         m_err = 0;
         if (ps) begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (m_pend[n] != 0) begin
                  m_duty[n] = m_shadow[n];
                  m_pend[n] = 0;
               end
            end
         end
         if (dv) begin
            m_sil = 0;
            if (m_count == 0) begin
               if (rxb == 8'hA5) m_count = 1;
            end else if (m_count < 3) begin
               m_frame[m_count] = int'(rxb);
               m_count++;
            end else begin
               m_count = 0;
               if ((int'(rxb) == (32'hA5 ^ m_frame[1] ^ m_frame[2])) && (m_frame[1] < NUM_CH)) begin
                  m_shadow[m_frame[1]] = m_frame[2];
                  m_pend[m_frame[1]]   = 1;
                  m_ack = 1;
               end else begin
                  m_err = 1;
                  if (m_cnt < 255) m_cnt++;
               end
            end
         end else if (m_count != 0) begin
            m_sil++;
            if (m_sil == TIMEOUT) begin
               m_count = 0;
               m_sil   = 0;
               m_err   = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int n = 0; n < NUM_CH; n++) begin
            checkOutput($sformatf("model duty ch%0d", n), 32'(duty[8*n +: 8]), 32'(m_duty[n]));
         end
         checkOutput("model ack", 32'(ack), 32'(m_ack));
         checkOutput("model err", 32'(err), 32'(m_err));
         checkOutput("model err_count", 32'(err_count), 32'(m_cnt));
         checkOutput("model busy", 32'(busy), 32'(m_count != 0));
      end
   end

   // Directed scenarios with literal expectations
   initial begin
      rst = 1'b1;
      dv  = 1'b0;
      rxb = 8'h00;
      ps  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Reset state and a valid frame to channel 2 committed at the period pulse
      doReset();
      checkOutput("reset duty", 32'(duty), 32'h0);
      checkOutput("reset err_count", 32'(err_count), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      sendFrame(8'hA5, 8'h02, 8'h80, 8'h27, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ch2 ack pulse", 32'(ack), 32'h1);
      checkOutput("ch2 duty before commit", 32'(duty[23:16]), 32'h00);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ch2 duty after commit", 32'(duty), 32'h0080_0000);

      // Bad checksum: error, count 1, nothing committed
      doReset();
      sendFrame(8'hA5, 8'h01, 8'h40, 8'hE0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bad csum err pulse", 32'(err), 32'h1);
      checkOutput("bad csum err_count", 32'(err_count), 32'h1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bad csum no commit", 32'(duty), 32'h0);

      // Out-of-range channel with a correct checksum
      doReset();
      sendFrame(8'hA5, 8'h07, 8'h10, 8'hB2, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("bad channel err pulse", 32'(err), 32'h1);
      checkOutput("bad channel ack", 32'(ack), 32'h0);
      checkOutput("bad channel err_count", 32'(err_count), 32'h1);

      // Inter-byte timeout, then a full frame is still accepted
      doReset();
      applyStimulus(1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("timeout err pulse", 32'(err), 32'h1);
      checkOutput("timeout busy", 32'(busy), 32'h0);
      checkOutput("timeout err_count", 32'(err_count), 32'h1);
      sendFrame(8'hA5, 8'h00, 8'h33, 8'h96, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("after timeout ack", 32'(ack), 32'h1);

      // Shadow write coinciding with a period pulse on the same channel
      doReset();
      sendFrame(8'hA5, 8'h03, 8'h20, 8'h86, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      sendFrame(8'hA5, 8'h03, 8'hC0, 8'h66, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("coincident commit old", 32'(duty[31:24]), 32'h20);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("coincident commit new", 32'(duty[31:24]), 32'hC0);

      // Back-to-back frames to one channel: last write wins
      doReset();
      sendFrame(8'hA5, 8'h00, 8'h11, 8'hB4, 1'b0);
      sendFrame(8'hA5, 8'h00, 8'h22, 8'h87, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("back-to-back ack", 32'(ack), 32'h1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("last write wins", 32'(duty[7:0]), 32'h22);

      // Stray bytes are ignored, then the error count saturates
      doReset();
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("stray err_count", 32'(err_count), 32'h0);
      checkOutput("stray busy", 32'(busy), 32'h0);
      for (int i = 0; i < 300; i++) begin
         sendFrame(8'hA5, 8'h01, 8'h40, 8'hE0, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("saturated err_count", 32'(err_count), 32'hFF);

      // Reset in the middle of a frame clears everything without pulses
      doReset();
      sendFrame(8'hA5, 8'h02, 8'h80, 8'h27, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("pre-reset duty", 32'(duty), 32'h0080_0000);
      doReset();
      checkOutput("mid-frame reset duty", 32'(duty), 32'h0);
      checkOutput("mid-frame reset busy", 32'(busy), 32'h0);
      checkOutput("mid-frame reset err", 32'(err), 32'h0);
      applyStimulus(1'b1, 8'hF1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("post-reset ack", 32'(ack), 32'h0);
      checkOutput("post-reset err_count", 32'(err_count), 32'h0);

      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_pwm_cmd_ctrl.md
Name: uart_pwm_cmd_ctrl

Overview:
- Command controller between the UART receiver and a bank of PWM generators.
- Parses 4-byte command frames from the receiver's byte/data-valid stream and holds per-channel 8-bit duty values in shadow registers.
- Commits duty values to the active registers that drive the PWM generators only at a PWM period boundary, so no glitched periods occur.
- Reports frame acknowledge, frame error and a saturating error count.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- TIMEOUT_CLKS, 8680, max clocks between bytes inside a frame (4 byte-times at 217 clks/bit × 10 bits).
- HDR_BYTE, 8'hA5, frame header value.

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_RX_DV  input  1  one-cycle pulse; i_RX_Byte valid.
- i_RX_Byte  input  8  received byte.
- i_Period_Start  input  1  one-cycle pulse from the PWM counter at period wrap (shared by all channels).
- o_Duty  output  NUM_CH*8  active duty values; channel n at bits [8n+7:8n].
- o_Cmd_Ack  output  1  one-cycle pulse: valid frame accepted into shadow.
- o_Cmd_Err  output  1  one-cycle pulse: frame rejected.
- o_Err_Count  output  8  saturating count of rejected frames.
- o_Busy  output  1  high while the parser is not in IDLE.

Behaviour:
- Clock and reset: single clock i_Clock; i_Reset is synchronous and active-high.
- Reset values: state IDLE; o_Duty, all shadow registers, pending flags, o_Cmd_Ack, o_Cmd_Err, o_Err_Count and the timeout counter all 0; o_Busy 0. Reset mid-frame discards the frame and produces no ack or err pulse.
- Frame format: HDR, CH, DUTY, CSUM, where CSUM = HDR ^ CH ^ DUTY.
- FSM states: IDLE -> GET_CH -> GET_DUTY -> GET_CSUM -> IDLE. Each transition occurs only on i_RX_DV.
- IDLE:
  - A byte equal to HDR_BYTE moves to GET_CH.
  - Any other byte is silently ignored: no err, no count.
- GET_CH and GET_DUTY latch the received byte.
- GET_CSUM is evaluated on the cycle its byte arrives; the FSM returns to IDLE that same cycle.
  - CSUM match and CH < NUM_CH: shadow[CH] <= DUTY, pending[CH] <= 1, o_Cmd_Ack pulses on the next cycle.
  - CSUM mismatch, or CH >= NUM_CH: no write; o_Cmd_Err pulses on the next cycle; o_Err_Count increments, saturating at 255.
  - Latency from final-byte DV to the ack/err pulse is 1 clock.
- Timeout:
  - The timeout counter clears on every i_RX_DV and counts while the state is not IDLE.
  - On reaching TIMEOUT_CLKS: return to IDLE, pulse o_Cmd_Err, increment o_Err_Count.
  - DV and timeout in the same cycle: the DV wins and the counter clears.
- Commit: on i_Period_Start, for every channel with pending=1, o_Duty[ch] <= shadow[ch] and pending clears. The new value is visible the cycle after the pulse.
- Simultaneous shadow write and i_Period_Start, same channel: the commit uses the old shadow; the new value is written to shadow and pending stays 1, so it commits at the next period start. Other channels commit normally.
- Repeated writes to a channel before a commit: last write wins; only one commit occurs.
- Back-to-back frames: a HDR byte arriving the cycle after a CSUM is accepted normally; no idle gap is required.
- o_Busy = (state != IDLE), combinational from the state register.
- o_Err_Count: 8-bit; holds at 8'hFF.

Test Plan:
- Reset, then frame A5,02,80,27, then i_Period_Start -> o_Cmd_Ack pulses 1 clk after the CSUM DV; o_Duty[23:16] stays 00 until the cycle after i_Period_Start, then reads 80; other channels stay 00.
- Frame A5,01,40,E0 (bad CSUM; correct value is E4) -> o_Cmd_Err pulses, o_Err_Count=1, shadow[1] unchanged, no commit on the next period start.
- Frame A5,07,10,B2 (valid CSUM, channel 7 >= 4) -> o_Cmd_Err pulse, o_Err_Count=1, no channel written.
- Send A5,00 then hold for 8680 clocks -> o_Cmd_Err pulse, FSM back to IDLE, o_Busy=0. The following full frame A5,00,33,96 is then accepted.
- CSUM DV of frame A5,03,C0,66 coincides with i_Period_Start while channel 3 holds a pending 20 -> o_Duty ch3=20 after this pulse, then C0 after the next i_Period_Start.
- Stray bytes 00,FF in IDLE -> no err; 300 bad frames -> o_Err_Count saturates at FF. Assert i_Reset mid-frame -> all outputs 0, no pulses.
